decode_stage: RTL and testbench

Registered, parametrised RV32/RV64 instruction-decode pipeline stage sitting between fetch and register-read/execute. It accepts one instruction and PC per cycle over a valid/ready handshake, decodes fields, type flags and a fully sign-extended XLEN-wide immediate, and flags illegal encodings. A two-entry skid buffer keeps `ready_o` registered, so there is no combinational path from `ready_i` to `ready_o`. A flush input discards in-flight instructions on branch redirect.

---
 rtl/decode_stage.sv | 263 ++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Registered RV32/RV64 instruction-decode pipeline stage. One instruction and
// its PC are accepted per cycle over a valid/ready handshake. The stage decodes
// the register and function fields, one-hot type flags and a sign-extended
// XLEN-wide immediate, and flags illegal encodings. A two-entry skid buffer
// (main register M, skid register K) keeps ready_o straight off a flop.
//
// Parameters
//   XLEN   : datapath width, 32 or 64 (64 also enables OP-IMM-32 / OP-32)
//   M_EXT  : 1 accepts R-type funct7 = 0000001 (mul/div)
//
// Ports
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   flush_i            : discard every held entry
//   valid_i / ready_o  : upstream handshake
//   instr_i, pc_i      : raw instruction and its PC
//   valid_o / ready_i  : downstream handshake
//   pc_o               : PC of the presented entry
//   rs1_o rs2_o rd_o   : register specifiers
//   op_o funct3_o funct7_o : opcode and function fields
//   is_{r,i,s,b,u,j}_o : one-hot type flags, all 0 when illegal
//   imm_o              : sign-extended immediate, 0 for R-type and illegal
//   illegal_o          : illegal encoding
// All data outputs read 0 whenever valid_o is 0.
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN  = 32,
    parameter bit M_EXT = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [6:0]      op_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic            is_r_o,
    output logic            is_i_o,
    output logic            is_s_o,
    output logic            is_b_o,
    output logic            is_u_o,
    output logic            is_j_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam bit         RV64      = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      op;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            is_r;
        logic            is_i;
        logic            is_s;
        logic            is_b;
        logic            is_u;
        logic            is_j;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundle_t;

    // State bit 0 is M.valid and bit 1 is K.valid, so valid_o and ready_o
    // come straight off the state flops with no decoding.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t  r_state;
    state_t  w_state_next;
    bundle_t r_m;
    bundle_t r_k;
    bundle_t w_dec;
    bundle_t w_out;

    logic w_accept;
    logic w_retire;
    logic w_load_m_in;
    logic w_load_m_k;
    logic w_load_k;

    logic [6:0]        w_op;
    logic [6:0]        w_funct7;
    logic [2:0]        w_funct3;
    logic              w_r_op;
    logic              w_i_op;
    logic              w_s_op;
    logic              w_b_op;
    logic              w_u_op;
    logic              w_j_op;
    logic              w_funct7_ok;
    logic              w_illegal;
    logic signed [11:0] w_imm_i;
    logic signed [11:0] w_imm_s;
    logic signed [12:0] w_imm_b;
    logic signed [31:0] w_imm_u;
    logic signed [20:0] w_imm_j;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    always_comb begin
        w_op     = instr_i[6:0];
        w_funct3 = instr_i[14:12];
        w_funct7 = instr_i[31:25];

        w_r_op = (w_op == OP_OP) || (RV64 && (w_op == OP_OP32));
        w_i_op = (w_op == OP_IMM) || (w_op == OP_LOAD) || (w_op == OP_JALR) ||
                 (RV64 && (w_op == OP_IMM32));
        w_s_op = (w_op == OP_STORE);
        w_b_op = (w_op == OP_BRANCH);
        w_u_op = (w_op == OP_LUI) || (w_op == OP_AUIPC);
        w_j_op = (w_op == OP_JAL);

        w_funct7_ok = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000) ||
                      (M_EXT && (w_funct7 == 7'b0000001));

        w_illegal = (instr_i[1:0] != 2'b11) ||
                    !(w_r_op || w_i_op || w_s_op || w_b_op || w_u_op || w_j_op) ||
                    (w_r_op && !w_funct7_ok) ||
                    ((w_op == OP_JALR) && (w_funct3 != 3'b000));

        w_imm_i = instr_i[31:20];
        w_imm_s = {instr_i[31:25], instr_i[11:7]};
        w_imm_b = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        w_imm_u = {instr_i[31:12], 12'b0};
        w_imm_j = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

        w_dec         = '0;
        w_dec.pc      = pc_i;
        w_dec.rs1     = instr_i[19:15];
        w_dec.rs2     = instr_i[24:20];
        w_dec.rd      = instr_i[11:7];
        w_dec.op      = w_op;
        w_dec.funct3  = w_funct3;
        w_dec.funct7  = w_funct7;
        w_dec.illegal = w_illegal;

        // Flags and immediate stay zero for illegal encodings; the signed
        // size casts perform the sign extension to XLEN.
        if (!w_illegal) begin
            w_dec.is_r = w_r_op;
            w_dec.is_i = w_i_op;
            w_dec.is_s = w_s_op;
            w_dec.is_b = w_b_op;
            w_dec.is_u = w_u_op;
            w_dec.is_j = w_j_op;
            if (w_i_op)      w_dec.imm = XLEN'(w_imm_i);
            else if (w_s_op) w_dec.imm = XLEN'(w_imm_s);
            else if (w_b_op) w_dec.imm = XLEN'(w_imm_b);
            else if (w_u_op) w_dec.imm = XLEN'(w_imm_u);
            else if (w_j_op) w_dec.imm = XLEN'(w_imm_j);
        end
    end

    // ------------------------------------------------------------------
    // Skid-buffer control
    // ------------------------------------------------------------------
    assign valid_o  = r_state[0];
    assign ready_o  = ~r_state[1];
    assign w_accept = valid_i & ready_o;
    assign w_retire = valid_o & ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load_m_in  = 1'b0;
        w_load_m_k   = 1'b0;
        w_load_k     = 1'b0;
        // A flush drops any same-cycle accept; a same-cycle retire has
        // already been seen downstream, so nothing else needs undoing.
        if (flush_i) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_load_m_in  = 1'b1;
                        w_state_next = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (w_accept && w_retire) begin
                        w_load_m_in = 1'b1;
                    end else if (w_retire) begin
                        w_state_next = ST_EMPTY;
                    end else if (w_accept) begin
                        w_load_k     = 1'b1;
                        w_state_next = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // ready_o is low here, so only a retire can happen.
                    if (w_retire) begin
                        w_load_m_k   = 1'b1;
                        w_state_next = ST_HALF;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    // Payload registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_load_m_in)     r_m <= w_dec;
        else if (w_load_m_k) r_m <= r_k;
        if (w_load_k)        r_k <= w_dec;
    end

    // ------------------------------------------------------------------
    // Outputs, forced to zero while M is empty
    // ------------------------------------------------------------------
    assign w_out     = r_state[0] ? r_m : '0;
    assign pc_o      = w_out.pc;
    assign rs1_o     = w_out.rs1;
    assign rs2_o     = w_out.rs2;
    assign rd_o      = w_out.rd;
    assign op_o      = w_out.op;
    assign funct3_o  = w_out.funct3;
    assign funct7_o  = w_out.funct7;
    assign is_r_o    = w_out.is_r;
    assign is_i_o    = w_out.is_i;
    assign is_s_o    = w_out.is_s;
    assign is_b_o    = w_out.is_b;
    assign is_u_o    = w_out.is_u;
    assign is_j_o    = w_out.is_j;
    assign imm_o     = w_out.imm;
    assign illegal_o = w_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Drives an RV64 and an RV32 instance of decode_stage with identical stimulus
// and compares both against a queue-based reference model whose decode is
// computed arithmetically from the instruction-set rules.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush_i;
    logic        valid_i;
    logic        ready_i;
    logic [31:0] instr_i;
    logic [63:0] pc_i;

    // RV64 instance outputs
    logic        a_ready, a_valid;
    logic [63:0] a_pc, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [6:0]  a_op, a_f7;
    logic [2:0]  a_f3;
    logic        a_r, a_i, a_s, a_b, a_u, a_j, a_ill;

    // RV32 instance outputs
    logic        b_ready, b_valid;
    logic [31:0] b_pc, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [6:0]  b_op, b_f7;
    logic [2:0]  b_f3;
    logic        b_r, b_i, b_s, b_b, b_u, b_j, b_ill;

    int checks = 0;
    int errors = 0;

    decode_stage #(.XLEN(64), .M_EXT(1'b0)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(a_ready),
        .instr_i(instr_i), .pc_i(pc_i), .valid_o(a_valid), .ready_i(ready_i), .pc_o(a_pc),
        .rs1_o(a_rs1), .rs2_o(a_rs2), .rd_o(a_rd), .op_o(a_op), .funct3_o(a_f3), .funct7_o(a_f7),
        .is_r_o(a_r), .is_i_o(a_i), .is_s_o(a_s), .is_b_o(a_b), .is_u_o(a_u), .is_j_o(a_j),
        .imm_o(a_imm), .illegal_o(a_ill)
    );

    decode_stage #(.XLEN(32), .M_EXT(1'b0)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(b_ready),
        .instr_i(instr_i), .pc_i(pc_i[31:0]), .valid_o(b_valid), .ready_i(ready_i), .pc_o(b_pc),
        .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd), .op_o(b_op), .funct3_o(b_f3), .funct7_o(b_f7),
        .is_r_o(b_r), .is_i_o(b_i), .is_s_o(b_s), .is_b_o(b_b), .is_u_o(b_u), .is_j_o(b_j),
        .imm_o(b_imm), .illegal_o(b_ill)
    );

    // ------------------------------------------------------------------
    // Reference model: FIFO of accepted {instr, pc}, at most two deep
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    ent_t q[$];

    function automatic logic [166:0] model(input ent_t e, input int xlen);
        logic [31:0] x;
        logic [6:0]  op;
        bit          r, i, s, b, u, j, ill;
        longint      imm, sg;
        logic [63:0] mask;
        x  = e.instr;
        op = x[6:0];
        r  = (op == 7'h33) || (xlen == 64 && op == 7'h3B);
        i  = (op inside {7'h13, 7'h03, 7'h67}) || (xlen == 64 && op == 7'h1B);
        s  = (op == 7'h23);
        b  = (op == 7'h63);
        u  = (op inside {7'h37, 7'h17});
        j  = (op == 7'h6F);
        ill = (x[1:0] != 2'b11) || !(r || i || s || b || u || j) ||
              (r && !(x[31:25] inside {7'h00, 7'h20})) ||
              (op == 7'h67 && x[14:12] != 3'b000);
        sg  = longint'(x[31]);
        imm = 0;
        if (i) imm = longint'(x[30:20]) - sg * 2048;
        if (s) imm = longint'(x[30:25]) * 32 + longint'(x[11:7]) - sg * 2048;
        if (b) imm = longint'(x[11:8]) * 2 + longint'(x[30:25]) * 32 +
                     longint'(x[7]) * 2048 - sg * 4096;
        if (u) imm = longint'(x[30:12]) * 4096 - sg * (longint'(1) << 31);
        if (j) imm = longint'(x[30:21]) * 2 + longint'(x[20]) * 2048 +
                     longint'(x[19:12]) * 4096 - sg * (longint'(1) << 20);
        if (ill || r) imm = 0;
        if (ill) begin
            r = 0; i = 0; s = 0; b = 0; u = 0; j = 0;
        end
        mask = (xlen == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
        return {e.pc & mask, x[19:15], x[24:20], x[11:7], op, x[14:12], x[31:25],
                r, i, s, b, u, j, 64'(imm) & mask, ill};
    endfunction

    function automatic logic [168:0] expect_full(input int xlen);
        logic [166:0] bun;
        bun = '0;
        if (q.size() > 0) bun = model(q[0], xlen);
        return {q.size() > 0, q.size() < 2, bun};
    endfunction

    function automatic logic [168:0] got64();
        return {a_valid, a_ready, a_pc, a_rs1, a_rs2, a_rd, a_op, a_f3, a_f7,
                a_r, a_i, a_s, a_b, a_u, a_j, a_imm, a_ill};
    endfunction

    function automatic logic [168:0] got32();
        return {b_valid, b_ready, 32'h0, b_pc, b_rs1, b_rs2, b_rd, b_op, b_f3, b_f7,
                b_r, b_i, b_s, b_b, b_u, b_j, 32'h0, b_imm, b_ill};
    endfunction

    // Advance one clock: model follows the handshake seen at the edge, then
    // the bench lands on the falling edge to sample and drive.
    task automatic tick();
        bit acc, ret;
        acc = valid_i && (q.size() < 2);
        ret = (q.size() > 0) && ready_i;
        @(posedge clk);
        if (ret) $display("retire pc=%h instr=%h flush=%0b", q[0].pc, q[0].instr, flush_i);
        if (flush_i) begin
            q.delete();
        end else begin
            if (ret) void'(q.pop_front());
            if (acc) q.push_back('{instr_i, pc_i});
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0]  ops [12];
        logic [31:0] x;
        int          k;
        ops = '{7'h33, 7'h3B, 7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        x = $urandom;
        k = $urandom_range(0, 13);
        if (k < 12) x[6:0] = ops[k];
        case ($urandom_range(0, 3))
            0: x[31:25] = 7'h00;
            1: x[31:25] = 7'h20;
            2: x[31:25] = 7'h01;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) x[14:12] = 3'b000;
        return x;
    endfunction

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        flush_i = 0; valid_i = 0; ready_i = 0; instr_i = 32'h0; pc_i = 64'h0;
        rst_n = 1;
        #2 rst_n = 0;
        #10;
        checks++;
        if (got64() !== {1'b0, 1'b1, 167'h0}) begin
            errors++;
            $display("FAIL reset64 got=%h want=%h", got64(), {1'b0, 1'b1, 167'h0});
        end
        checks++;
        if (got32() !== {1'b0, 1'b1, 167'h0}) begin
            errors++;
            $display("FAIL reset32 got=%h want=%h", got32(), {1'b0, 1'b1, 167'h0});
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_addi();
        ready_i = 1; valid_i = 1; instr_i = 32'hFFF00093; pc_i = 64'h1000;
        tick();
        valid_i = 0;
        checks++;
        if ({a_valid, a_r, a_i, a_s, a_b, a_u, a_j, a_rd, a_imm, a_ill} !==
            {1'b1, 6'b010000, 5'd1, {64{1'b1}}, 1'b0}) begin
            errors++;
            $display("FAIL addi valid=%0b flags=%b rd=%0d imm=%h ill=%0b want 1 010000 1 ffffffffffffffff 0",
                     a_valid, {a_r, a_i, a_s, a_b, a_u, a_j}, a_rd, a_imm, a_ill);
        end
        checks++;
        if (got64() !== expect_full(64)) begin
            errors++;
            $display("FAIL addi_model got=%h want=%h", got64(), expect_full(64));
        end
        tick();
        checks++;
        if (a_valid !== 1'b0) begin
            errors++;
            $display("FAIL addi_drain valid=%0b want 0", a_valid);
        end
    endtask

    task automatic test_back_to_back();
        ready_i = 1; valid_i = 1; instr_i = 32'hFE000EE3; pc_i = 64'h2000;
        tick();
        instr_i = 32'h0000006F; pc_i = 64'h2004;
        checks++;
        if ({a_valid, a_b, a_imm} !== {1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin
            errors++;
            $display("FAIL b2b_beq valid=%0b is_b=%0b imm=%h want 1 1 fffffffffffffffc", a_valid, a_b, a_imm);
        end
        tick();
        valid_i = 0;
        checks++;
        if ({a_valid, a_j, a_imm, a_pc} !== {1'b1, 1'b1, 64'h0, 64'h2004}) begin
            errors++;
            $display("FAIL b2b_jal valid=%0b is_j=%0b imm=%h pc=%h want 1 1 0 2004", a_valid, a_j, a_imm, a_pc);
        end
        tick();
        checks++;
        if (got64() !== expect_full(64)) begin
            errors++;
            $display("FAIL b2b_drain got=%h want=%h", got64(), expect_full(64));
        end
    endtask

    task automatic test_stall();
        ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            valid_i = 1;
            instr_i = 32'h00500013 | (32'(k + 1) << 7);
            pc_i    = 64'h3000 + 64'(4 * k);
            tick();
            checks++;
            if (got64() !== expect_full(64)) begin
                errors++;
                $display("FAIL stall_fill%0d got=%h want=%h", k, got64(), expect_full(64));
            end
            if (k >= 1) begin
                checks++;
                if ({a_ready, a_pc} !== {1'b0, 64'h3000}) begin
                    errors++;
                    $display("FAIL stall_ready%0d ready=%0b pc=%h want 0 3000", k, a_ready, a_pc);
                end
            end
        end
        valid_i = 0;
        ready_i = 1;
        tick();
        checks++;
        if ({a_valid, a_ready, a_pc, a_rd} !== {1'b1, 1'b1, 64'h3004, 5'd2}) begin
            errors++;
            $display("FAIL stall_drain1 valid=%0b ready=%0b pc=%h rd=%0d want 1 1 3004 2",
                     a_valid, a_ready, a_pc, a_rd);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (got64() !== expect_full(64)) begin
                errors++;
                $display("FAIL stall_drain%0d got=%h want=%h", k + 2, got64(), expect_full(64));
            end
        end
    endtask

    task automatic test_flush_full();
        ready_i = 0;
        for (int k = 0; k < 2; k++) begin
            valid_i = 1; instr_i = 32'h00000037 | (32'(k + 5) << 7); pc_i = 64'h4000 + 64'(4 * k);
            tick();
        end
        checks++;
        if ({a_valid, a_ready} !== 2'b10) begin
            errors++;
            $display("FAIL flush_full valid=%0b ready=%0b want 1 0", a_valid, a_ready);
        end
        flush_i = 1; valid_i = 1; instr_i = 32'h12345037; pc_i = 64'hDEAD0;
        tick();
        flush_i = 0; valid_i = 0;
        checks++;
        if ({a_valid, a_ready, b_valid, b_ready} !== 4'b0101) begin
            errors++;
            $display("FAIL flush_clear v64=%0b r64=%0b v32=%0b r32=%0b want 0 1 0 1",
                     a_valid, a_ready, b_valid, b_ready);
        end
        ready_i = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (got64() !== {1'b0, 1'b1, 167'h0}) begin
                errors++;
                $display("FAIL flush_ghost%0d got=%h want empty", k, got64());
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] cases [5];
        cases = '{32'h00000000, 32'h0000001B, 32'h02000033, 32'h00001067, 32'h0000007F};
        ready_i = 1;
        for (int k = 0; k < 5; k++) begin
            valid_i = 1; instr_i = cases[k]; pc_i = 64'h5000 + 64'(4 * k);
            tick();
            checks++;
            if ({b_valid, b_ill, b_r, b_i, b_s, b_b, b_u, b_j, b_imm} !== {1'b1, 1'b1, 6'b0, 32'h0}) begin
                errors++;
                $display("FAIL illegal32_%0d instr=%h valid=%0b ill=%0b flags=%b imm=%h want 1 1 000000 0",
                         k, cases[k], b_valid, b_ill, {b_r, b_i, b_s, b_b, b_u, b_j}, b_imm);
            end
            checks++;
            if (a_ill !== (k != 1)) begin
                errors++;
                $display("FAIL illegal64_%0d instr=%h ill=%0b want %0b", k, cases[k], a_ill, (k != 1));
            end
            checks++;
            if (got64() !== expect_full(64)) begin
                errors++;
                $display("FAIL illegal_model%0d got=%h want=%h", k, got64(), expect_full(64));
            end
        end
        valid_i = 0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 19) == 0);
            instr_i = gen_instr();
            pc_i    = {$urandom, $urandom};
            tick();
            checks++;
            if (got64() !== expect_full(64)) begin
                errors++;
                $display("FAIL rand64 cyc=%0d got=%h want=%h", c, got64(), expect_full(64));
            end
            checks++;
            if (got32() !== expect_full(32)) begin
                errors++;
                $display("FAIL rand32 cyc=%0d got=%h want=%h", c, got32(), expect_full(32));
            end
        end
        flush_i = 0; valid_i = 0;
    endtask

    task automatic test_reset_midstream();
        ready_i = 1; valid_i = 0; flush_i = 0;
        repeat (3) tick();
        ready_i = 0;
        for (int k = 0; k < 2; k++) begin
            valid_i = 1; instr_i = gen_instr(); pc_i = 64'h6000 + 64'(4 * k);
            tick();
        end
        valid_i = 0;
        checks++;
        if ({a_valid, a_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_full valid=%0b ready=%0b want 1 0", a_valid, a_ready);
        end
        rst_n = 0;
        #1;
        q.delete();
        checks++;
        if (got64() !== {1'b0, 1'b1, 167'h0}) begin
            errors++;
            $display("FAIL rstmid64 got=%h want empty", got64());
        end
        checks++;
        if (got32() !== {1'b0, 1'b1, 167'h0}) begin
            errors++;
            $display("FAIL rstmid32 got=%h want empty", got32());
        end
        #2 rst_n = 1;
        @(negedge clk);
        ready_i = 1;
        for (int c = 0; c < 12; c++) begin
            valid_i = 1; instr_i = gen_instr(); pc_i = 64'h7000 + 64'(4 * c);
            ready_i = (c < 4) || ($urandom_range(0, 1) == 1);
            tick();
            checks++;
            if (got64() !== expect_full(64)) begin
                errors++;
                $display("FAIL rstmid_resume%0d got=%h want=%h", c, got64(), expect_full(64));
            end
        end
        valid_i = 0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_flush_full();
        test_illegal();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
